// File: rtl/weight_fetch_ctlr.sv
// weight_fetch_ctlr
//   Weight/bias fetch controller. Holds a programmable per-layer descriptor
//   table, computes the packed start index of a fetch, reads packed weight
//   words from a single-port SRAM and unpacks them to one weight per cycle,
//   optionally followed by one bias read. Shares the SRAM port with system
//   preload, which has priority and kills any fetch in progress.
// Ports
//   clk, rst                  clock, async active-high reset
//   i_cfg_*                   descriptor table write port
//   i_req/o_req_ready         fetch handshake; i_layer/i_if_ch/i_of_ch request
//   o_wt_valid/data/last/mode unpacked weight stream
//   o_bias_valid/data         bias strobe (data zero unless if_ch == 0)
//   o_done, o_abort           completion / pre-emption pulses
//   i_sys_*                   system SRAM access (owns port when i_sys_load)
//   o_sram_*, i_sram_q        SRAM port, active-low controls
module weight_fetch_ctlr #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int WT_W       = 8,
    parameter int NUM_LAYERS = 8,
    parameter int CH_W       = 5,
    parameter int SRAM_LAT   = 1
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_cfg_we,
    input  logic [$clog2(NUM_LAYERS)-1:0]            i_cfg_layer,
    input  logic [2:0]                               i_cfg_field,
    input  logic [ADDR_W+$clog2(DATA_W/WT_W)-1:0]    i_cfg_data,
    input  logic                                     i_req,
    output logic                                     o_req_ready,
    input  logic [$clog2(NUM_LAYERS)-1:0]            i_layer,
    input  logic [CH_W-1:0]                          i_if_ch,
    input  logic [CH_W-1:0]                          i_of_ch,
    output logic                                     o_wt_valid,
    output logic [WT_W-1:0]                          o_wt_data,
    output logic                                     o_wt_last,
    output logic [1:0]                               o_wt_mode,
    output logic                                     o_bias_valid,
    output logic [WT_W-1:0]                          o_bias_data,
    output logic                                     o_done,
    output logic                                     o_abort,
    input  logic                                     i_sys_load,
    input  logic                                     i_sys_ceb,
    input  logic                                     i_sys_web,
    input  logic [ADDR_W-1:0]                        i_sys_a,
    input  logic [DATA_W-1:0]                        i_sys_d,
    output logic                                     o_sram_ceb,
    output logic                                     o_sram_web,
    output logic [ADDR_W-1:0]                        o_sram_a,
    output logic [DATA_W-1:0]                        o_sram_d,
    input  logic [DATA_W-1:0]                        i_sram_q
);

    localparam int          PACK = DATA_W / WT_W;
    localparam int          LPW  = $clog2(PACK);
    localparam int          SW   = ADDR_W + LPW;
    localparam int unsigned LAST = SRAM_LAT - 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WRD  = 3'd1;
    localparam logic [2:0] S_BRD  = 3'd2;
    localparam logic [2:0] S_DRN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Descriptor table
    logic [SW-1:0]     wbase_t  [NUM_LAYERS];
    logic [SW-1:0]     taps_t   [NUM_LAYERS];
    logic [SW-1:0]     stride_t [NUM_LAYERS];
    logic [ADDR_W-1:0] bbase_t  [NUM_LAYERS];
    logic              hasb_t   [NUM_LAYERS];
    logic [1:0]        mode_t   [NUM_LAYERS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                wbase_t[i]  <= '0;
                taps_t[i]   <= '0;
                stride_t[i] <= '0;
                bbase_t[i]  <= '0;
                hasb_t[i]   <= 1'b0;
                mode_t[i]   <= '0;
            end
        end else if (i_cfg_we) begin
            case (i_cfg_field)
                3'd0: wbase_t[i_cfg_layer]  <= i_cfg_data;
                3'd1: taps_t[i_cfg_layer]   <= i_cfg_data;
                3'd2: stride_t[i_cfg_layer] <= i_cfg_data;
                3'd3: bbase_t[i_cfg_layer]  <= i_cfg_data[ADDR_W-1:0];
                3'd4: begin
                    hasb_t[i_cfg_layer] <= i_cfg_data[2];
                    mode_t[i_cfg_layer] <= i_cfg_data[1:0];
                end
                default: ;
            endcase
        end
    end

    // Fetch state
    logic [2:0]        state;
    logic [SW-1:0]     cnt;
    logic [ADDR_W-1:0] waddr;
    logic [LPW-1:0]    lane;
    logic              first;
    logic              hasb;
    logic [ADDR_W-1:0] bbase;
    logic [CH_W-1:0]   of_ch_r;
    logic              if_zero;
    logic [1:0]        mode_r;
    logic              abort_r;
    logic [DATA_W-1:0] unpack;

    // Read-return tag pipeline; index LAST lines up with i_sram_q
    logic              tag_v    [SRAM_LAT];
    logic              tag_b    [SRAM_LAT];
    logic              tag_f    [SRAM_LAT];
    logic              tag_l    [SRAM_LAT];
    logic [LPW-1:0]    tag_lane [SRAM_LAT];

    logic [SW-1:0]     start_idx;
    logic              issue_w, issue_b, kill, accept, inflight;
    logic [ADDR_W-1:0] fetch_a;
    logic [DATA_W-1:0] word;

    assign start_idx = wbase_t[i_layer] + SW'(i_of_ch) * stride_t[i_layer]
                     + SW'(i_if_ch) * taps_t[i_layer];

    assign o_req_ready = (state == S_IDLE) && !i_sys_load;

    always_comb begin
        issue_w  = (state == S_WRD) && (first || lane == '0);
        issue_b  = (state == S_BRD);
        kill     = i_sys_load && (state == S_WRD || state == S_BRD || state == S_DRN);
        accept   = i_req && o_req_ready;
        // Returns still short of the output stage keep DRN waiting
        inflight = 1'b0;
        for (int unsigned i = 0; i < LAST; i++) inflight = inflight | tag_v[i];
        fetch_a  = '0;
        if (issue_w)      fetch_a = waddr;
        else if (issue_b) fetch_a = bbase + ADDR_W'(of_ch_r);
    end

    always_comb begin
        if (i_sys_load) begin
            o_sram_ceb = i_sys_ceb;
            o_sram_web = i_sys_web;
            o_sram_a   = i_sys_a;
            o_sram_d   = i_sys_d;
        end else begin
            o_sram_ceb = !(issue_w || issue_b);
            o_sram_web = 1'b1;
            o_sram_a   = fetch_a;
            o_sram_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            waddr   <= '0;
            lane    <= '0;
            first   <= 1'b0;
            hasb    <= 1'b0;
            bbase   <= '0;
            of_ch_r <= '0;
            if_zero <= 1'b0;
            mode_r  <= '0;
            abort_r <= 1'b0;
            unpack  <= '0;
            for (int unsigned i = 0; i < SRAM_LAT; i++) begin
                tag_v[i]    <= 1'b0;
                tag_b[i]    <= 1'b0;
                tag_f[i]    <= 1'b0;
                tag_l[i]    <= 1'b0;
                tag_lane[i] <= '0;
            end
        end else begin
            abort_r <= kill;
            if (kill) begin
                state <= S_IDLE;
                for (int unsigned i = 0; i < SRAM_LAT; i++) tag_v[i] <= 1'b0;
            end else begin
                for (int unsigned i = LAST; i > 0; i--) begin
                    tag_v[i]    <= tag_v[i-1];
                    tag_b[i]    <= tag_b[i-1];
                    tag_f[i]    <= tag_f[i-1];
                    tag_l[i]    <= tag_l[i-1];
                    tag_lane[i] <= tag_lane[i-1];
                end
                tag_v[0]    <= (state == S_WRD) || (state == S_BRD);
                tag_b[0]    <= issue_b;
                tag_f[0]    <= issue_w;
                tag_l[0]    <= (state == S_WRD) && (cnt == SW'(1));
                tag_lane[0] <= lane;

                case (state)
                    S_IDLE: if (accept) begin
                        mode_r  <= mode_t[i_layer];
                        cnt     <= taps_t[i_layer];
                        waddr   <= start_idx[SW-1:LPW];
                        lane    <= start_idx[LPW-1:0];
                        first   <= 1'b1;
                        hasb    <= hasb_t[i_layer];
                        bbase   <= bbase_t[i_layer];
                        of_ch_r <= i_of_ch;
                        if_zero <= (i_if_ch == '0);
                        // An empty fetch passes through DRN so o_done lands at t+2
                        if (taps_t[i_layer] != '0) state <= S_WRD;
                        else if (hasb_t[i_layer])  state <= S_BRD;
                        else                       state <= S_DRN;
                    end
                    S_WRD: begin
                        first <= 1'b0;
                        lane  <= lane + 1'b1;
                        if (lane == '1) waddr <= waddr + 1'b1;
                        cnt   <= cnt - 1'b1;
                        if (cnt == SW'(1)) state <= hasb ? S_BRD : S_DRN;
                    end
                    S_BRD:  state <= S_DRN;
                    S_DRN:  if (!inflight) state <= S_DONE;
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
            if (o_wt_valid && tag_f[LAST]) unpack <= i_sram_q;
        end
    end

    // The first lane of a freshly read word comes straight off the SRAM bus
    assign word         = tag_f[LAST] ? i_sram_q : unpack;
    assign o_wt_valid   = tag_v[LAST] && !tag_b[LAST];
    assign o_wt_data    = o_wt_valid ? word[tag_lane[LAST]*WT_W +: WT_W] : '0;
    assign o_wt_last    = o_wt_valid && tag_l[LAST];
    assign o_bias_valid = tag_v[LAST] && tag_b[LAST];
    assign o_bias_data  = (o_bias_valid && if_zero) ? i_sram_q[WT_W-1:0] : '0;
    assign o_wt_mode    = mode_r;
    assign o_done       = (state == S_DONE);
    assign o_abort      = abort_r;

endmodule

// File: tb/tb_weight_fetch_ctlr.sv
// tb_weight_fetch_ctlr
//   Directed bench: dut1 uses SRAM_LAT=1, dut3 uses SRAM_LAT=3. Both share
//   reset, configuration, request fields and system-load inputs; each has its
//   own request strobe and its own SRAM read-latency model.
module tb_weight_fetch_ctlr;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_layer, cfg_field;
    logic [15:0] cfg_data;
    logic        req1, req3;
    logic [2:0]  layer;
    logic [4:0]  if_ch, of_ch;
    logic        sys_load, sys_ceb, sys_web;
    logic [13:0] sys_a;
    logic [31:0] sys_d;

    logic        ready1, wt_valid1, wt_last1, bias_valid1, done1, abort1;
    logic [7:0]  wt_data1, bias_data1;
    logic [1:0]  mode1;
    logic        sram_ceb1, sram_web1;
    logic [13:0] sram_a1;
    logic [31:0] sram_d1, q1;

    logic        ready3, wt_valid3, wt_last3, bias_valid3, done3, abort3;
    logic [7:0]  wt_data3, bias_data3;
    logic [1:0]  mode3;
    logic        sram_ceb3, sram_web3;
    logic [13:0] sram_a3;
    logic [31:0] sram_d3, q3, p3_0, p3_1;

    logic [4:0]  v1, v3;
    assign v1 = {wt_valid1, wt_last1, bias_valid1, done1, abort1};
    assign v3 = {wt_valid3, wt_last3, bias_valid3, done3, abort3};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    weight_fetch_ctlr #(.SRAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .i_cfg_we(cfg_we), .i_cfg_layer(cfg_layer),
        .i_cfg_field(cfg_field), .i_cfg_data(cfg_data), .i_req(req1),
        .o_req_ready(ready1), .i_layer(layer), .i_if_ch(if_ch), .i_of_ch(of_ch),
        .o_wt_valid(wt_valid1), .o_wt_data(wt_data1), .o_wt_last(wt_last1),
        .o_wt_mode(mode1), .o_bias_valid(bias_valid1), .o_bias_data(bias_data1),
        .o_done(done1), .o_abort(abort1), .i_sys_load(sys_load),
        .i_sys_ceb(sys_ceb), .i_sys_web(sys_web), .i_sys_a(sys_a), .i_sys_d(sys_d),
        .o_sram_ceb(sram_ceb1), .o_sram_web(sram_web1), .o_sram_a(sram_a1),
        .o_sram_d(sram_d1), .i_sram_q(q1));

    weight_fetch_ctlr #(.SRAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .i_cfg_we(cfg_we), .i_cfg_layer(cfg_layer),
        .i_cfg_field(cfg_field), .i_cfg_data(cfg_data), .i_req(req3),
        .o_req_ready(ready3), .i_layer(layer), .i_if_ch(if_ch), .i_of_ch(of_ch),
        .o_wt_valid(wt_valid3), .o_wt_data(wt_data3), .o_wt_last(wt_last3),
        .o_wt_mode(mode3), .o_bias_valid(bias_valid3), .o_bias_data(bias_data3),
        .o_done(done3), .o_abort(abort3), .i_sys_load(sys_load),
        .i_sys_ceb(sys_ceb), .i_sys_web(sys_web), .i_sys_a(sys_a), .i_sys_d(sys_d),
        .o_sram_ceb(sram_ceb3), .o_sram_web(sram_web3), .o_sram_a(sram_a3),
        .o_sram_d(sram_d3), .i_sram_q(q3));

    // SRAM contents: weight index k holds byte k+1; two bias words overridden
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        logic [15:0] b;
        b = {a, 2'b00};
        case (a)
            14'd5120: return 32'h1234_56A5;
            14'd6003: return 32'h0000_0077;
            default:  return {8'(b + 16'd4), 8'(b + 16'd3), 8'(b + 16'd2), 8'(b + 16'd1)};
        endcase
    endfunction

    always @(posedge clk) begin
        q1   <= (!sram_ceb1 && sram_web1) ? mem_word(sram_a1) : 32'hDEAD_BEEF;
        p3_0 <= (!sram_ceb3 && sram_web3) ? mem_word(sram_a3) : 32'hDEAD_BEEF;
        p3_1 <= p3_0;
        q3   <= p3_1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] l, input logic [2:0] f, input logic [15:0] d);
        cfg_we = 1'b1; cfg_layer = l; cfg_field = f; cfg_data = d;
        next_cycle();
        cfg_we = 1'b0;
    endtask

    task automatic req_dut1(input logic [2:0] l, input logic [4:0] ic, input logic [4:0] oc);
        layer = l; if_ch = ic; of_ch = oc; req1 = 1'b1;
        next_cycle();
        req1 = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (v1 !== 5'b0) $display("FAIL reset_strobes1 got %b want 00000", v1); else n_pass++;
        n_checks++; if (v3 !== 5'b0) $display("FAIL reset_strobes3 got %b want 00000", v3); else n_pass++;
        n_checks++; if (ready1 !== 1'b1) $display("FAIL reset_ready got %b want 1", ready1); else n_pass++;
        n_checks++; if (mode1 !== 2'd0) $display("FAIL reset_mode got %0d want 0", mode1); else n_pass++;
        n_checks++; if (wt_data1 !== 8'd0) $display("FAIL reset_wt_data got %h want 00", wt_data1); else n_pass++;
        n_checks++; if ({sram_ceb1, sram_web1, sram_a1, sram_d1} !== {1'b1, 1'b1, 14'd0, 32'd0})
            $display("FAIL reset_sram got ceb=%b web=%b a=%0d d=%h want 1 1 0 0", sram_ceb1, sram_web1, sram_a1, sram_d1);
        else n_pass++;
    endtask

    task automatic test_basic();
        cfg_write(3'd0, 3'd0, 16'd0);
        cfg_write(3'd0, 3'd1, 16'd25);
        cfg_write(3'd0, 3'd3, 16'd5120);
        cfg_write(3'd0, 3'd4, 16'b100);
        n_checks++; if (ready1 !== 1'b1) $display("FAIL basic_ready_pre got %b want 1", ready1); else n_pass++;
        req_dut1(3'd0, 5'd0, 5'd0);
        for (int c = 1; c <= 29; c++) begin
            logic [4:0] e;
            e = {(c >= 2 && c <= 26), c == 26, c == 27, c == 28, 1'b0};
            n_checks++; if (v1 !== e) $display("FAIL basic_strobes c=%0d got %b want %b", c, v1, e); else n_pass++;
            if (c >= 2 && c <= 26) begin
                n_checks++; if (wt_data1 !== 8'(c - 1)) $display("FAIL basic_wt c=%0d got %0d want %0d", c, wt_data1, c - 1); else n_pass++;
            end
            if (c == 27) begin
                n_checks++; if (bias_data1 !== 8'hA5) $display("FAIL basic_bias got %h want a5", bias_data1); else n_pass++;
            end
            n_checks++; if (ready1 !== (c == 29)) $display("FAIL basic_ready c=%0d got %b", c, ready1); else n_pass++;
            if (c == 1) begin
                n_checks++; if ({sram_ceb1, sram_a1} !== {1'b0, 14'd0}) $display("FAIL basic_rd0 got ceb=%b a=%0d want 0 0", sram_ceb1, sram_a1); else n_pass++;
            end
            if (c == 26) begin
                n_checks++; if ({sram_ceb1, sram_a1} !== {1'b0, 14'd5120}) $display("FAIL basic_rdb got ceb=%b a=%0d want 0 5120", sram_ceb1, sram_a1); else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_unaligned();
        cfg_write(3'd2, 3'd0, 16'd3600);
        cfg_write(3'd2, 3'd1, 16'd9);
        cfg_write(3'd2, 3'd2, 16'd200);
        cfg_write(3'd2, 3'd3, 16'd6000);
        cfg_write(3'd2, 3'd4, 16'b110);
        req_dut1(3'd2, 5'd2, 5'd3);
        for (int c = 1; c <= 12; c++) begin
            logic       rd;
            logic [13:0] ea;
            logic [4:0] e;
            rd = (c == 1 || c == 3 || c == 7 || c == 10);
            ea = (c == 1) ? 14'd1054 : (c == 3) ? 14'd1055 : (c == 7) ? 14'd1056 : 14'd6003;
            n_checks++; if (sram_ceb1 !== !rd) $display("FAIL unal_ceb c=%0d got %b want %b", c, sram_ceb1, !rd); else n_pass++;
            if (rd) begin
                n_checks++; if (sram_a1 !== ea) $display("FAIL unal_addr c=%0d got %0d want %0d", c, sram_a1, ea); else n_pass++;
            end
            e = {(c >= 2 && c <= 10), c == 10, c == 11, c == 12, 1'b0};
            n_checks++; if (v1 !== e) $display("FAIL unal_strobes c=%0d got %b want %b", c, v1, e); else n_pass++;
            if (c >= 2 && c <= 10) begin
                n_checks++; if (wt_data1 !== 8'(121 + c)) $display("FAIL unal_wt c=%0d got %0d want %0d", c, wt_data1, 121 + c); else n_pass++;
            end
            if (c == 11) begin
                n_checks++; if (bias_data1 !== 8'd0) $display("FAIL unal_bias got %h want 00", bias_data1); else n_pass++;
            end
            n_checks++; if (mode1 !== 2'd2) $display("FAIL unal_mode c=%0d got %0d want 2", c, mode1); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_zero_taps();
        n_checks++; if (ready1 !== 1'b1) $display("FAIL zero_ready_pre got %b want 1", ready1); else n_pass++;
        req_dut1(3'd3, 5'd0, 5'd0);
        for (int c = 1; c <= 3; c++) begin
            n_checks++; if (sram_ceb1 !== 1'b1) $display("FAIL zero_ceb c=%0d got %b want 1", c, sram_ceb1); else n_pass++;
            n_checks++; if (v1 !== {3'b000, c == 2, 1'b0}) $display("FAIL zero_strobes c=%0d got %b", c, v1); else n_pass++;
            n_checks++; if (ready1 !== (c == 3)) $display("FAIL zero_ready c=%0d got %b", c, ready1); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_abort();
        req_dut1(3'd0, 5'd0, 5'd0);
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) begin
                n_checks++; if (wt_data1 !== 8'd4) $display("FAIL abort_wt4 got %0d want 4", wt_data1); else n_pass++;
            end
            if (c == 6) begin
                sys_load = 1'b1; sys_ceb = 1'b0; sys_web = 1'b0;
                sys_a = 14'h1ABC; sys_d = 32'hCAFE_F00D;
                req1 = 1'b1; layer = 3'd3; if_ch = 5'd0; of_ch = 5'd0;
                #1;
                n_checks++; if ({sram_ceb1, sram_web1, sram_a1, sram_d1} !== {1'b0, 1'b0, 14'h1ABC, 32'hCAFE_F00D})
                    $display("FAIL abort_pins got ceb=%b web=%b a=%h d=%h", sram_ceb1, sram_web1, sram_a1, sram_d1);
                else n_pass++;
                n_checks++; if (ready1 !== 1'b0) $display("FAIL abort_ready6 got %b want 0", ready1); else n_pass++;
            end
            if (c >= 7 && c <= 9) begin
                n_checks++; if (v1 !== {4'b0000, c == 7}) $display("FAIL abort_strobes c=%0d got %b", c, v1); else n_pass++;
                n_checks++; if (ready1 !== 1'b0) $display("FAIL abort_ready c=%0d got %b want 0", c, ready1); else n_pass++;
            end
            if (c == 10) begin
                sys_load = 1'b0; sys_ceb = 1'b1; sys_web = 1'b1;
                #1;
                n_checks++; if (ready1 !== 1'b1) $display("FAIL abort_ready10 got %b want 1", ready1); else n_pass++;
                n_checks++; if (v1 !== 5'b0) $display("FAIL abort_strobes10 got %b want 00000", v1); else n_pass++;
            end
            next_cycle();
        end
        req1 = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            n_checks++; if (v1 !== {3'b000, k == 2, 1'b0}) $display("FAIL abort_held k=%0d got %b", k, v1); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_cfg_during_burst();
        cfg_write(3'd4, 3'd0, 16'd40);
        cfg_write(3'd4, 3'd1, 16'd3);
        req_dut1(3'd4, 5'd0, 5'd0);
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) begin cfg_we = 1'b1; cfg_layer = 3'd4; cfg_field = 3'd1; cfg_data = 16'd5; end
            if (c == 2) cfg_we = 1'b0;
            n_checks++; if (v1 !== {(c >= 2 && c <= 4), c == 4, 1'b0, c == 5, 1'b0}) $display("FAIL cfg1_strobes c=%0d got %b", c, v1); else n_pass++;
            if (c >= 2 && c <= 4) begin
                n_checks++; if (wt_data1 !== 8'(39 + c)) $display("FAIL cfg1_wt c=%0d got %0d want %0d", c, wt_data1, 39 + c); else n_pass++;
            end
            next_cycle();
        end
        n_checks++; if (ready1 !== 1'b1) $display("FAIL cfg_ready got %b want 1", ready1); else n_pass++;
        req_dut1(3'd4, 5'd0, 5'd0);
        for (int c = 1; c <= 8; c++) begin
            n_checks++; if (v1 !== {(c >= 2 && c <= 6), c == 6, 1'b0, c == 7, 1'b0}) $display("FAIL cfg2_strobes c=%0d got %b", c, v1); else n_pass++;
            if (c >= 2 && c <= 6) begin
                n_checks++; if (wt_data1 !== 8'(39 + c)) $display("FAIL cfg2_wt c=%0d got %0d want %0d", c, wt_data1, 39 + c); else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_lat3();
        cfg_write(3'd5, 3'd0, 16'd8);
        cfg_write(3'd5, 3'd1, 16'd7);
        cfg_write(3'd5, 3'd4, 16'b001);
        n_checks++; if (ready3 !== 1'b1) $display("FAIL lat3_ready_pre got %b want 1", ready3); else n_pass++;
        layer = 3'd5; if_ch = 5'd0; of_ch = 5'd0; req3 = 1'b1;
        next_cycle();
        req3 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            n_checks++; if (v3 !== {(c >= 4 && c <= 10), c == 10, 1'b0, c == 11, 1'b0}) $display("FAIL lat3_strobes c=%0d got %b", c, v3); else n_pass++;
            if (c >= 4 && c <= 10) begin
                n_checks++; if (wt_data3 !== 8'(5 + c)) $display("FAIL lat3_wt c=%0d got %0d want %0d", c, wt_data3, 5 + c); else n_pass++;
            end
            n_checks++; if (mode3 !== 2'd1) $display("FAIL lat3_mode c=%0d got %0d want 1", c, mode3); else n_pass++;
            n_checks++; if (ready3 !== (c == 12)) $display("FAIL lat3_ready c=%0d got %b", c, ready3); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_reset_midburst();
        layer = 3'd5; if_ch = 5'd0; of_ch = 5'd0; req3 = 1'b1;
        next_cycle();
        req3 = 1'b0;
        for (int c = 1; c < 5; c++) next_cycle();
        n_checks++; if (wt_data3 !== 8'd10) $display("FAIL rstmid_wt got %0d want 10", wt_data3); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (v3 !== 5'b0) $display("FAIL rstmid_strobes got %b want 00000", v3); else n_pass++;
        n_checks++; if (mode3 !== 2'd0) $display("FAIL rstmid_mode got %0d want 0", mode3); else n_pass++;
        n_checks++; if (wt_data3 !== 8'd0) $display("FAIL rstmid_data got %h want 00", wt_data3); else n_pass++;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            n_checks++; if (v3 !== 5'b0) $display("FAIL rstpost_strobes k=%0d got %b", k, v3); else n_pass++;
            n_checks++; if (ready3 !== 1'b1) $display("FAIL rstpost_ready k=%0d got %b want 1", k, ready3); else n_pass++;
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;
        req1 = 1'b0; req3 = 1'b0; layer = '0; if_ch = '0; of_ch = '0;
        sys_load = 1'b0; sys_ceb = 1'b1; sys_web = 1'b1; sys_a = '0; sys_d = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        test_reset();
        test_basic();
        test_unaligned();
        test_zero_taps();
        test_abort();
        test_cfg_during_burst();
        test_lat3();
        test_reset_midburst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
